// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
//   Handshake and data bundle for the bit-serial add/subtract sequencer.
//   master: drives start/sub/a/b, observes busy/done/sum/cout/overflow.
//   slave : the sequencer itself.
// Signals
//   start     request, sampled only while the sequencer is idle
//   sub       0 = a+b, 1 = a-b, sampled with start
//   a, b      operands, sampled with start
//   busy      high while bits are being processed
//   done      one-cycle pulse when the result is ready
//   sum       result, held until the next accepted start
//   cout      carry out of the MSB (for subtraction: 1 = no borrow)
//   overflow  signed overflow
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract sequencer. One 1-bit full adder (two half adders plus an OR
//   for the carry) is stepped LSB-first over WIDTH cycles with a carry flip-flop.
//   Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
// Ports
//   i_clk  rising-edge clock
//   i_rst  asynchronous, active-high reset
//   bus    serial_add_ctrl_if.slave (start/sub/a/b in; busy/done/sum/cout/overflow out)
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    // Full adder built from two half adders; carry out is the OR of both half-adder carries.
    logic w_ha0_s, w_ha0_c;
    logic w_ha1_s, w_ha1_c;
    logic w_carry;
    logic w_last;

    assign w_ha0_s = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha0_c = r_a_sh[0] & r_b_sh[0];
    assign w_ha1_s = w_ha0_s ^ r_carry;
    assign w_ha1_c = w_ha0_s & r_carry;
    assign w_carry = w_ha0_c | w_ha1_c;
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_carry;
                    r_sum   <= {w_ha1_s, r_sum[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // r_carry is still the carry into the MSB here.
                        r_cout  <= w_carry;
                        r_ovf   <= r_carry ^ w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed-vector bench for serial_add_ctrl (WIDTH=8) with hand-computed results.
module tb_serial_add_ctrl;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Runs one operation. With inject set, a stray start (a=b=1) is pulsed at RUN cycle 3
    // and again during DONE; both must be ignored.
    task automatic run_op(input string tag, input logic sub, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf, input bit inject);
        int edges;
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = sub;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Operand changes after accept must not matter.
        bus.a     = ~a;
        bus.b     = a;
        bus.sub   = ~sub;
        edges     = 0;
        while (!bus.done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (inject && edges == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
            end else begin
                bus.start = 1'b0;
            end
        end
        check_eq({tag, "_latency"}, 32'(edges), 32'(WIDTH));
        check_eq({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check_eq({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        if (inject) begin
            bus.start = 1'b1;
            bus.a     = 8'h01;
            bus.b     = 8'h01;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_no_accept"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp_sum));
    endtask

    initial begin
        int edges;
        int dones;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_sum", 32'(bus.sum), 32'd0);
        rst = 1'b0;

        run_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("inject", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1);

        // Abort with an asynchronous reset at RUN cycle 4.
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 8'h5A;
        bus.b     = 8'h3C;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        check_eq("arst_done", 32'(bus.done), 32'd0);
        check_eq("arst_sum", 32'(bus.sum), 32'd0);
        check_eq("arst_cout", 32'(bus.cout), 32'd0);
        check_eq("arst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (edges = 0; edges < 12; edges++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        check_eq("arst_no_done", 32'(dones), 32'd0);
        run_op("post_rst_3_4", 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0);

        if (n_fail == 0) $display("All tests passed");
        else $display("Some tests failed");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
